// File: rtl/parser_head_realign.sv
// parser_head_realign: strips a per-packet number of leading units from a
// sliced packet stream and repacks the remainder into full output slices.
module parser_head_realign #(
  parameter int DATA_W = 512,
  parameter int UNIT_W = 8,
  parameter int MAX_SHIFT = 255,
  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1),
  localparam int UNITS = DATA_W / UNIT_W,
  localparam int CNT_W = $clog2(UNITS + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_start,
  input  logic               i_tail,
  input  logic [CNT_W-1:0]   i_cnt,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_start,
  output logic               o_tail,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_drop,
  output logic               o_err
);

  localparam int RES_W = DATA_W - UNIT_W;
  localparam int CAT_W = 2 * DATA_W - UNIT_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PKT   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]         r_state;
  logic [SHIFT_W-1:0] r_skip;
  logic [RES_W-1:0]   r_res;
  logic [CNT_W-1:0]   r_res_cnt;
  logic               r_first;
  logic               r_live;

  logic               w_acc, w_go, w_bad, w_abort;
  logic               w_first, w_full, w_emit, w_drop;
  logic [SHIFT_W-1:0] w_skip;
  logic [RES_W-1:0]   w_res;
  logic [31:0]        w_rc, w_cnt, w_sk, w_d, w_k, w_tot;
  logic [DATA_W-1:0]  w_in, w_new;
  logic [CAT_W-1:0]   w_cat;

  assign o_ready = r_live & (r_state != S_FLUSH) & (~o_valid | i_ready);

  // A start beat sees an empty residue, so an abandoned packet leaves no trace.
  always_comb begin
    w_acc   = i_valid & o_ready;
    w_go    = w_acc & (i_start | (r_state == S_PKT));
    w_bad   = w_acc & ~i_start & (r_state == S_IDLE);
    w_abort = w_acc & i_start & (r_state == S_PKT);
    w_skip  = i_start ? i_shift : r_skip;
    w_res   = i_start ? '0 : r_res;
    w_rc    = i_start ? '0 : 32'(r_res_cnt);
    w_first = i_start | r_first;
    w_cnt   = 32'(i_cnt);
    w_sk    = 32'(w_skip);
    w_d     = (w_sk < w_cnt) ? w_sk : w_cnt;
    w_k     = w_cnt - w_d;
    w_tot   = w_rc + w_k;
    w_in    = i_data & ~({DATA_W{1'b1}} >> (w_cnt * UNIT_W));
    w_new   = w_in << (w_d * UNIT_W);
    w_cat   = {w_res, {DATA_W{1'b0}}}
            | ({w_new, {RES_W{1'b0}}} >> (w_rc * UNIT_W));
    w_full  = w_tot >= UNITS;
    w_emit  = w_go & (w_full | (i_tail & (w_tot != 0)));
    w_drop  = w_go & i_tail & (w_tot == 0) & w_first;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_skip    <= '0;
      r_res     <= '0;
      r_res_cnt <= '0;
      r_first   <= 1'b0;
      r_live    <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_start   <= 1'b0;
      o_tail    <= 1'b0;
      o_cnt     <= '0;
      o_drop    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      o_drop <= w_drop;
      o_err  <= w_bad | w_abort;
      if (r_state == S_FLUSH) begin
        if (i_ready) begin
          o_valid   <= 1'b1;
          o_data    <= {r_res, {UNIT_W{1'b0}}};
          o_cnt     <= r_res_cnt;
          o_start   <= 1'b0;
          o_tail    <= 1'b1;
          r_res     <= '0;
          r_res_cnt <= '0;
          r_state   <= S_IDLE;
        end
      end else if (w_emit) begin
        o_valid <= 1'b1;
        o_data  <= w_cat[CAT_W-1 -: DATA_W];
        o_cnt   <= w_full ? CNT_W'(UNITS) : CNT_W'(w_tot);
        o_start <= w_first;
        o_tail  <= i_tail & (w_tot <= UNITS);
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (w_go) begin
        r_skip  <= SHIFT_W'(w_sk - w_d);
        r_first <= w_first & ~w_emit;
        if (i_tail && w_tot <= UNITS) begin
          r_res     <= '0;
          r_res_cnt <= '0;
          r_state   <= S_IDLE;
        end else if (w_full) begin
          r_res     <= w_cat[RES_W-1:0];
          r_res_cnt <= CNT_W'(w_tot - UNITS);
          r_state   <= i_tail ? S_FLUSH : S_PKT;
        end else begin
          r_res     <= w_cat[CAT_W-1 -: RES_W];
          r_res_cnt <= CNT_W'(w_tot);
          r_state   <= S_PKT;
        end
      end
    end
  end

endmodule

// File: doc/parser_head_realign.md
# parser_head_realign

Parametrised successor to the parser's single-slice head shifter: strips a per-packet number of leading units (bytes by default) from a sliced packet stream and re-packs the remainder into full output slices. Unlike the previous shifter it supports strips longer than one slice, valid/ready backpressure, a partial tail slice with unit count, and whole-packet drop. It sits between parser stages, after the stage that computes the header length to remove.

## Interface
- DATA_W, 512, slice width in bits; must be a multiple of UNIT_W
- UNIT_W, 8, shift granularity in bits
- MAX_SHIFT, 255, largest strip in units; SHIFT_W = clog2(MAX_SHIFT+1)
- Derived: UNITS = DATA_W/UNIT_W; CNT_W = clog2(UNITS+1)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid / o_ready  in / out  1  input handshake; beat accepted when both high
- i_data  in  DATA_W  unit 0 in bits [DATA_W-1 -: UNIT_W] (network order)
- i_start, i_tail  in  1  first / last beat of packet; may be set together
- i_cnt  in  CNT_W  valid units in beat, 1..UNITS; must equal UNITS unless i_tail
- i_shift  in  SHIFT_W  units to strip; sampled only on the start beat
- o_valid / i_ready  out / in  1  output handshake
- o_data  out  DATA_W  realigned slice; units beyond o_cnt are zero
- o_start, o_tail  out  1  first / last output beat of packet
- o_cnt  out  CNT_W  valid units in o_data
- o_drop  out  1  one-cycle pulse: packet entirely stripped, nothing emitted
- o_err  out  1  one-cycle pulse: framing error (see Operation)

## Operation
- States: IDLE (no packet open), PKT (packet open), FLUSH (tail accepted, residue > 0 still to emit).
- Registers: skip (SHIFT_W), residue buffer (UNITS-1 units) with res_cnt, first_out flag, output register.
- Accepted beat: d = min(skip, i_cnt) leading units dropped, skip -= d; remaining k = i_cnt-d units appended behind residue.
- If res_cnt+k >= UNITS: emit one full slice (residue then new units), keep res_cnt+k-UNITS units as residue.
- Tail beat: if res_cnt+k <= UNITS emit it all as the tail slice (o_cnt = res_cnt+k) -> IDLE; if > UNITS emit full slice, go FLUSH, next cycle emit leftover as tail slice -> IDLE.
- Tail with res_cnt+k = 0 and no earlier output: o_drop pulse, no output beat. If output already emitted and final chunk empty, last emitted beat must carry o_tail (one-beat lookahead: hold a full slice until the next input shows whether more units follow).
- o_start set on the first output beat of each packet.
- IDLE + beat without i_start: beat discarded, o_err pulse. PKT + i_start: open packet abandoned (residue, held slice cleared, nothing emitted for it), o_err pulse, new packet begins with this beat.
- i_shift = 0: pure pass-through with same framing and o_cnt.

## Timing
- Reset: o_valid, o_start, o_tail, o_drop, o_err = 0; o_data, o_cnt = 0; o_ready = 0 in reset, 1 in the first cycle after; state IDLE; residue empty.
- o_ready = (state != FLUSH) & (~o_valid | i_ready); no combinational path i_valid -> o_ready.
- An output beat appears on o_valid the cycle after the input beat that completes it (including lookahead); FLUSH beat one cycle later, o_ready low that cycle.
- Output held stable while o_valid & ~i_ready.
- o_drop / o_err assert the cycle after the offending/tail beat is accepted, independent of i_ready.
- Reset mid-packet: everything cleared immediately; next beat must carry i_start.
- Full throughput (one beat per cycle) when i_ready stays high, except the FLUSH bubble.

## Test plan
- DATA_W=64, UNIT_W=8 (UNITS=8), packet bytes 0x00.. ascending.
- Shift 0, 3 beats cnt 8,8,5 -> 3 beats identical, o_start on first, o_tail+o_cnt=5 on third, no bubble.
- Shift 3, 2 beats cnt 8,8 -> out 03..0A then 0B..0F o_cnt=5 o_tail; o_ready low one cycle (FLUSH).
- Shift 10, 3 beats cnt 8,8,8 -> out 0A..11, then 12..17 o_cnt=6 o_tail; first beat entirely dropped.
- Shift 20, 2 beats cnt 8,4 -> no o_valid, o_drop single pulse cycle after tail; shift 12 same packet -> o_drop too; shift 11 -> one beat 0B o_cnt=1.
- Shift 3, 5-beat packets back-to-back with random i_ready/i_valid -> scoreboard matches, no loss/duplication, o_data stable while stalled.
- Start, no tail, then new start -> o_err pulse, only second packet emitted; non-start beat after reset -> o_err; reset asserted mid-packet -> outputs 0, next packet clean.
